// File: rtl/add64_seq_ctrl.sv
// 64-bit adder that reuses one 32-bit adder over two cycles (LO half, then HI half).
// Optional signed-overflow output Ovf_o is built only when ADD64_SEQ_OVF_EN is defined.

module Adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

module add64_seq_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] A_i,
    input  logic [63:0] B_i,
    input  logic        Cin_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] Sum_o,
    output logic        Cout_o
`ifdef ADD64_SEQ_OVF_EN
    ,
    output logic        Ovf_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] op_a_q, op_b_q;
    logic        op_cin_q;
    logic        carry_q;
    logic [31:0] sum_lo_q;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    // The single adder is steered to the upper halves only while in HI.
    always_comb begin
        add_a   = op_a_q[31:0];
        add_b   = op_b_q[31:0];
        add_cin = op_cin_q;
        if (state_q == HI) begin
            add_a   = op_a_q[63:32];
            add_b   = op_b_q[63:32];
            add_cin = carry_q;
        end
    end

    Adder_32_bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_i) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            carry_q  <= 1'b0;
            sum_lo_q <= '0;
            Sum_o    <= '0;
            Cout_o   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (valid_i) begin
                    op_a_q   <= A_i;
                    op_b_q   <= B_i;
                    op_cin_q <= Cin_i;
                end
                LO: begin
                    sum_lo_q <= add_sum;
                    carry_q  <= add_cout;
                end
                HI: begin
                    Sum_o  <= {add_sum, sum_lo_q};
                    Cout_o <= add_cout;
                end
                default: ;
            endcase
        end
    end

`ifdef ADD64_SEQ_OVF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            Ovf_o <= 1'b0;
        else if (state_q == HI)
            Ovf_o <= (op_a_q[63] == op_b_q[63]) && (add_sum[31] != op_a_q[63]);
    end
`endif

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Self-checking bench for add64_seq_ctrl: directed vector table plus handshake corner sequences.
// Ovf_o is connected and checked only when ADD64_SEQ_OVF_EN is defined.

module tb_add64_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] A_i, B_i;
    logic        Cin_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] Sum_o;
    logic        Cout_o;
`ifdef ADD64_SEQ_OVF_EN
    logic        Ovf_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    add64_seq_ctrl dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .A_i     (A_i),
        .B_i     (B_i),
        .Cin_i   (Cin_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .Sum_o   (Sum_o),
        .Cout_o  (Cout_o)
`ifdef ADD64_SEQ_OVF_EN
        ,
        .Ovf_o   (Ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] s, input logic c, input logic o);
        check({name, "_sum"}, Sum_o, s);
        check({name, "_cout"}, {63'b0, Cout_o}, {63'b0, c});
`ifdef ADD64_SEQ_OVF_EN
        check({name, "_ovf"}, {63'b0, Ovf_o}, {63'b0, o});
`else
        if (o === 1'bx) $display("unexpected unknown overflow reference");
`endif
    endtask

    // Accept one operand set from IDLE and walk the FSM to DONE, checking handshake timing.
    task automatic issue(input string name, input logic [63:0] a, input logic [63:0] b, input logic cin);
        check({name, "_rdy_idle"}, {63'b0, ready_o}, 64'd1);
        A_i = a; B_i = b; Cin_i = cin; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        A_i = '1; B_i = '1; Cin_i = 1'b1;
        check({name, "_rdy_lo"}, {63'b0, ready_o}, 64'd0);
        check({name, "_vld_lo"}, {63'b0, valid_o}, 64'd0);
        tick();
        check({name, "_vld_hi"}, {63'b0, valid_o}, 64'd0);
        tick();
        check({name, "_vld_done"}, {63'b0, valid_o}, 64'd1);
        check({name, "_rdy_done"}, {63'b0, ready_o}, 64'd0);
    endtask

    task automatic retire(input string name);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check({name, "_rdy_back"}, {63'b0, ready_o}, 64'd1);
        check({name, "_vld_back"}, {63'b0, valid_o}, 64'd0);
    endtask

    initial begin
        logic [64:0]  ref65;
        logic [63:0]  q_sum[$];
        logic         q_cout[$];
        logic         q_ovf[$];
        int           n_acc, n_res, last_c;
        logic [63:0]  ra, rb;
        logic         rc;

        vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0};

        // Reset with a pending input handshake that must be ignored.
        rst_n_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        A_i = 64'h1; B_i = 64'h1; Cin_i = 1'b0;
        tick();
        tick();
        check("rst_ready", {63'b0, ready_o}, 64'd1);
        check("rst_valid", {63'b0, valid_o}, 64'd0);
        check_result("rst", 64'h0, 1'b0, 1'b0);
        valid_i = 1'b0;
        rst_n_i = 1'b1;
        tick();
        check("post_rst_idle", {63'b0, ready_o}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin);
            check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            retire($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d_hold", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Backpressure: result held, new operands offered but not taken.
        issue("bp", 64'h5, 64'h3, 1'b0);
        A_i = 64'd100; B_i = 64'd1; Cin_i = 1'b0; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {63'b0, valid_o}, 64'd1);
            check("bp_ready", {63'b0, ready_o}, 64'd0);
            check_result("bp", 64'h8, 1'b0, 1'b0);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("bp_idle_rdy", {63'b0, ready_o}, 64'd1);
        check("bp_idle_vld", {63'b0, valid_o}, 64'd0);
        check_result("bp_idle", 64'h8, 1'b0, 1'b0);
        tick();
        valid_i = 1'b0;
        check("bp_accept", {63'b0, ready_o}, 64'd0);
        tick();
        tick();
        check("bp_next_vld", {63'b0, valid_o}, 64'd1);
        check_result("bp_next", 64'd101, 1'b0, 1'b0);
        retire("bp_next");

        // Reset while in HI discards the operation.
        check("mid_pre_rdy", {63'b0, ready_o}, 64'd1);
        A_i = 64'hFFFF_0000_FFFF_0000; B_i = 64'h1; Cin_i = 1'b0; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check("mid_rst_vld", {63'b0, valid_o}, 64'd0);
        check("mid_rst_rdy", {63'b0, ready_o}, 64'd1);
        check_result("mid_rst", 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_quiet", {63'b0, valid_o}, 64'd0);
        end
        issue("after_rst", 64'h5, 64'h3, 1'b0);
        check_result("after_rst", 64'h8, 1'b0, 1'b0);
        retire("after_rst");

        // Streaming with both handshake inputs held high.
        n_acc = 0; n_res = 0; last_c = -1;
        ready_i = 1'b1; valid_i = 1'b1;
        for (int c = 0; c < 80 && n_res < 8; c++) begin
            if (ready_o) begin
                if (n_acc < 8) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    rc = 1'($urandom_range(1, 0));
                    A_i = ra; B_i = rb; Cin_i = rc;
                    ref65 = {1'b0, ra} + {1'b0, rb} + {64'b0, rc};
                    q_sum.push_back(ref65[63:0]);
                    q_cout.push_back(ref65[64]);
                    q_ovf.push_back((ra[63] == rb[63]) && (ref65[63] != ra[63]));
                    n_acc++;
                end else begin
                    valid_i = 1'b0;
                end
            end
            if (valid_o) begin
                if (q_sum.size() == 0) begin
                    check("stream_extra", {63'b0, valid_o}, 64'd0);
                end else begin
                    check_result("stream", q_sum.pop_front(), q_cout.pop_front(), q_ovf.pop_front());
                    if (last_c >= 0) check("stream_gap", 64'(c - last_c), 64'd4);
                    last_c = c;
                end
                n_res++;
            end
            tick();
        end
        check("stream_count", 64'(n_res), 64'd8);
        valid_i = 1'b0; ready_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
